// File: rtl/clk_en_sched.sv
// -----------------------------------------------------------------------------
// clk_en_sched
//
// Scheduler for clock enables. A shared prescaler wraps every PRE_DIV cycles
// and emits base_tick. Each of the NCH channels holds a period P, an enable
// and a down-counter. On every prescaler wrap, an enabled channel whose
// counter is zero reloads P, pulses ch_tick and toggles ch_clk. An enabled
// channel whose counter is nonzero decrements it. The result is one pulse
// every P+1 base ticks, and ch_clk is a level that toggles at that rate.
//
// Ports
//   clk         single clock; all state changes on its rising edge
//   rst         synchronous, active-high reset
//   cfg_valid   configuration write request
//   cfg_ready   a write can be accepted this cycle (low in the prescaler's
//               terminal cycle and during reset)
//   cfg_ch      target channel; indices >= NCH complete the handshake and
//               change nothing
//   cfg_period  new period P for the target channel
//   cfg_en      new enable for the target channel
//   base_tick   one-cycle registered pulse on each prescaler wrap
//   ch_tick     per-channel one-cycle enable pulses, aligned with base_tick
//   ch_clk      per-channel toggling divided-clock levels (0 when disabled)
//   active      per-channel enable bits
// -----------------------------------------------------------------------------
module clk_en_sched #(
  parameter int PRE_DIV = 1048576,  // prescale ratio, 2 .. 2^20
  parameter int NCH     = 4,        // number of channels, 1 .. 8
  parameter int PER_W   = 8,        // period / counter width
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [PER_W-1:0] cfg_period,
  input  logic             cfg_en,
  output logic             base_tick,
  output logic [NCH-1:0]   ch_tick,
  output logic [NCH-1:0]   ch_clk,
  output logic [NCH-1:0]   active
);

  // Terminal prescaler value. PRE_DIV can be as large as 2^20, so PRE_DIV-1
  // always fits the 20-bit counter.
  localparam logic [19:0] PRE_LAST = 20'(PRE_DIV - 1);

  // ---------------------------------------------------------------------------
  // Prescaler and base tick
  // ---------------------------------------------------------------------------
  logic [19:0] pre_q;
  logic [19:0] pre_d;
  logic        base_tick_q;
  logic        base_tick_d;
  logic        wrap;

  always_comb begin
    wrap        = (pre_q == PRE_LAST);
    pre_d       = wrap ? 20'd0 : (pre_q + 20'd1);
    // Registered, so the pulse appears the cycle after the terminal count.
    base_tick_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q       <= 20'd0;
      base_tick_q <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      base_tick_q <= base_tick_d;
    end
  end

  assign base_tick = base_tick_q;

  // ---------------------------------------------------------------------------
  // Configuration handshake
  //
  // Writes are refused in the wrap cycle. As a result, a channel never sees a
  // write and a wrap update in the same cycle, which keeps the per-channel
  // next-state logic a simple priority chain. The prescaler itself never
  // looks at the write path, so writes cannot disturb the base_tick phase.
  // ---------------------------------------------------------------------------
  logic wr_acc;

  assign cfg_ready = ~rst & ~wrap;
  assign wr_acc    = cfg_valid & cfg_ready;

  // ---------------------------------------------------------------------------
  // Channels
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [PER_W-1:0] period_q;
      logic [PER_W-1:0] period_d;
      logic [PER_W-1:0] cnt_q;
      logic [PER_W-1:0] cnt_d;
      logic             en_q;
      logic             en_d;
      logic             tick_q;
      logic             tick_d;
      logic             clk_q;
      logic             clk_d;
      logic             sel;

      always_comb begin
        // Out-of-range cfg_ch values match no channel, so those writes
        // complete the handshake but change nothing.
        sel      = wr_acc && (cfg_ch == CH_W'(gi));
        period_d = period_q;
        cnt_d    = cnt_q;
        en_d     = en_q;
        clk_d    = clk_q;
        tick_d   = 1'b0;

        if (sel) begin
          // Loading the counter with P puts the first pulse on base tick P+1
          // after the write. Clearing ch_clk restarts the divided clock at a
          // known level.
          period_d = cfg_period;
          en_d     = cfg_en;
          cnt_d    = cfg_period;
          clk_d    = 1'b0;
        end else if (!en_q) begin
          // Disabled: the counter holds its value and the level is forced low.
          clk_d = 1'b0;
        end else if (wrap) begin
          if (cnt_q == '0) begin
            cnt_d  = period_q;
            tick_d = 1'b1;
            clk_d  = ~clk_q;
          end else begin
            cnt_d = cnt_q - PER_W'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          period_q <= '0;
          cnt_q    <= '0;
          en_q     <= 1'b0;
          tick_q   <= 1'b0;
          clk_q    <= 1'b0;
        end else begin
          period_q <= period_d;
          cnt_q    <= cnt_d;
          en_q     <= en_d;
          tick_q   <= tick_d;
          clk_q    <= clk_d;
        end
      end

      assign ch_tick[gi] = tick_q;
      assign ch_clk[gi]  = clk_q;
      assign active[gi]  = en_q;
    end
  endgenerate

endmodule

// File: tb/tb_clk_en_sched.sv
// -----------------------------------------------------------------------------
// tb_clk_en_sched
//
// Directed bench for clk_en_sched with PRE_DIV=4, NCH=4 and PER_W=8.
// A second instance with NCH=3 shares all inputs. On that instance a write to
// channel 3 is out of range, so the handshake completes and no state changes.
// cyc counts the clock cycles since reset release. Cycle 0 is the window
// right after the last reset edge. Outputs are sampled 1 time unit after each
// rising edge. With PRE_DIV=4, base_tick is high when cyc%4==0 (cyc>0), and
// cfg_ready is low when cyc%4==3.
// -----------------------------------------------------------------------------
module tb_clk_en_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_ch = 2'd0;
  logic [7:0] cfg_period = 8'd0;
  logic       cfg_en = 1'b0;

  logic       cfg_ready;
  logic       base_tick;
  logic [3:0] ch_tick;
  logic [3:0] ch_clk;
  logic [3:0] active;

  logic       cfg_ready3;
  logic       base_tick3;
  logic [2:0] ch_tick3;
  logic [2:0] ch_clk3;
  logic [2:0] active3;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  clk_en_sched #(.PRE_DIV(4), .NCH(4), .PER_W(8)) u_dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_en(cfg_en),
    .base_tick(base_tick), .ch_tick(ch_tick), .ch_clk(ch_clk), .active(active)
  );

  clk_en_sched #(.PRE_DIV(4), .NCH(3), .PER_W(8)) u_dut3 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready3),
    .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_en(cfg_en),
    .base_tick(base_tick3), .ch_tick(ch_tick3), .ch_clk(ch_clk3), .active(active3)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cfg_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
    #1;
  endtask

  // Issue one write and hold cfg_valid until cfg_ready is seen. The task
  // returns in the cycle after acceptance with cfg_valid dropped.
  task automatic wr(input int ch, input int p, input bit en);
    bit done;
    int start;
    done = 1'b0;
    start = cyc;
    cfg_valid = 1'b1;
    cfg_ch = 2'(ch);
    cfg_period = 8'(p);
    cfg_en = en;
    for (int w = 0; w < 8 && !done; w++) begin
      if (cfg_ready) done = 1'b1;
      step();
    end
    cfg_valid = 1'b0;
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL wr_accept ch=%0d: cfg_ready stayed 0 for 8 cycles, required acceptance", ch);
    end
    $display("[TB] write ch=%0d P=%0d en=%0d issued cyc=%0d accepted_by cyc=%0d", ch, p, en, start, cyc);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_tests++;
    if ({base_tick, cfg_ready, ch_tick, ch_clk, active} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got bt=%b rdy=%b tick=%b clk=%b act=%b required all 0",
               base_tick, cfg_ready, ch_tick, ch_clk, active);
    end
    rst = 1'b0;
    cyc = 0;
    #1;
    n_tests++;
    if (cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready got %b required 1", cfg_ready);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_idle();
    logic exp_bt;
    logic exp_rdy;
    for (int k = 0; k < 16; k++) begin
      step();
      exp_bt  = (cyc % 4 == 0);
      exp_rdy = (cyc % 4 != 3);
      n_tests++;
      if ({base_tick, cfg_ready, ch_tick, ch_clk, active} !== {exp_bt, exp_rdy, 12'd0}) begin
        n_fail++;
        $display("FAIL idle cyc=%0d got bt=%b rdy=%b tick=%b clk=%b act=%b required bt=%b rdy=%b rest 0",
                 cyc, base_tick, cfg_ready, ch_tick, ch_clk, active, exp_bt, exp_rdy);
      end
    end
    $display("[TB] idle run checked through cyc=%0d", cyc);
  endtask

  task automatic test_single();
    logic       exp_bt;
    logic [3:0] exp_tick;
    logic [3:0] exp_clk;
    do_reset();
    wr(1, 2, 1'b1);
    // P=2 gives pulses on base ticks 3, 6, 9..., which fall at cycles 12, 24, 36.
    for (int k = 0; k < 40; k++) begin
      exp_bt   = (cyc % 4 == 0);
      exp_tick = (cyc % 12 == 0) ? 4'b0010 : 4'b0000;
      exp_clk  = ((cyc / 12) % 2 == 1) ? 4'b0010 : 4'b0000;
      n_tests++;
      if ({base_tick, ch_tick, ch_clk, active} !== {exp_bt, exp_tick, exp_clk, 4'b0010}) begin
        n_fail++;
        $display("FAIL single_ch1 cyc=%0d got bt=%b tick=%b clk=%b act=%b required bt=%b tick=%b clk=%b act=0010",
                 cyc, base_tick, ch_tick, ch_clk, active, exp_bt, exp_tick, exp_clk);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic       exp_bt;
    logic [3:0] exp_tick;
    logic [3:0] exp_clk;
    do_reset();
    wr(0, 0, 1'b1);
    wr(3, 1, 1'b1);
    for (int k = 0; k < 32; k++) begin
      exp_bt   = (cyc % 4 == 0);
      exp_tick = {(cyc % 8 == 0), 2'b00, (cyc % 4 == 0)};
      exp_clk  = {((cyc / 8) % 2 == 1), 2'b00, ((cyc / 4) % 2 == 1)};
      n_tests++;
      if ({base_tick, ch_tick, ch_clk, active} !== {exp_bt, exp_tick, exp_clk, 4'b1001}) begin
        n_fail++;
        $display("FAIL back_to_back cyc=%0d got bt=%b tick=%b clk=%b act=%b required bt=%b tick=%b clk=%b act=1001",
                 cyc, base_tick, ch_tick, ch_clk, active, exp_bt, exp_tick, exp_clk);
      end
      step();
    end
  endtask

  task automatic test_terminal();
    do_reset();
    step();
    step();
    step();
    // cyc=3 is the prescaler terminal cycle.
    cfg_valid = 1'b1;
    cfg_ch = 2'd2;
    cfg_period = 8'd0;
    cfg_en = 1'b1;
    #1;
    n_tests++;
    if ({cfg_ready, base_tick} !== 2'b00) begin
      n_fail++;
      $display("FAIL terminal_ready cyc=%0d got rdy=%b bt=%b required 0/0", cyc, cfg_ready, base_tick);
    end
    step();
    n_tests++;
    if ({base_tick, cfg_ready, ch_tick, active} !== {2'b11, 8'h00}) begin
      n_fail++;
      $display("FAIL terminal_held cyc=%0d got bt=%b rdy=%b tick=%b act=%b required 1/1/0000/0000",
               cyc, base_tick, cfg_ready, ch_tick, active);
    end
    step();
    cfg_valid = 1'b0;
    $display("[TB] write ch=2 P=0 en=1 held over terminal cycle, accepted_by cyc=%0d", cyc);
    n_tests++;
    if ({base_tick, active} !== 5'b0_0100) begin
      n_fail++;
      $display("FAIL terminal_accept cyc=%0d got bt=%b act=%b required 0/0100", cyc, base_tick, active);
    end
    step();
    step();
    step();
    n_tests++;
    if ({base_tick, ch_tick, ch_clk} !== 9'b1_0100_0100) begin
      n_fail++;
      $display("FAIL terminal_phase cyc=%0d got bt=%b tick=%b clk=%b required 1/0100/0100",
               cyc, base_tick, ch_tick, ch_clk);
    end
  endtask

  task automatic test_disable();
    logic exp_bt;
    bit   seen;
    do_reset();
    wr(2, 0, 1'b1);
    step();
    step();
    step();
    n_tests++;
    if ({base_tick, ch_tick, ch_clk} !== 9'b1_0100_0100) begin
      n_fail++;
      $display("FAIL disable_pre cyc=%0d got bt=%b tick=%b clk=%b required 1/0100/0100",
               cyc, base_tick, ch_tick, ch_clk);
    end
    wr(2, 0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      exp_bt = (cyc % 4 == 0);
      n_tests++;
      if ({base_tick, ch_tick, ch_clk, active} !== {exp_bt, 12'd0}) begin
        n_fail++;
        $display("FAIL disable_quiet cyc=%0d got bt=%b tick=%b clk=%b act=%b required bt=%b rest 0",
                 cyc, base_tick, ch_tick, ch_clk, active, exp_bt);
      end
      step();
    end
    // cfg_ch=3 is out of range for the NCH=3 instance.
    wr(3, 0, 1'b1);
    n_tests++;
    if ({active, active3} !== 7'b1000_000) begin
      n_fail++;
      $display("FAIL out_of_range_active got act=%b act3=%b required 1000/000", active, active3);
    end
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      step();
      if (base_tick) seen = 1'b1;
    end
    n_tests++;
    if ({seen, base_tick3, ch_tick, ch_tick3, ch_clk3, active3} !== {2'b11, 4'b1000, 9'd0}) begin
      n_fail++;
      $display("FAIL out_of_range_tick cyc=%0d got seen=%b bt3=%b tick=%b tick3=%b clk3=%b act3=%b required 1/1/1000/000/000/000",
               cyc, seen, base_tick3, ch_tick, ch_tick3, ch_clk3, active3);
    end
  endtask

  task automatic test_reset_mid();
    logic exp_bt;
    do_reset();
    wr(1, 0, 1'b1);
    for (int k = 0; k < 5; k++) step();
    n_tests++;
    if ({ch_clk, active} !== 8'b0010_0010) begin
      n_fail++;
      $display("FAIL reset_mid_pre cyc=%0d got clk=%b act=%b required 0010/0010", cyc, ch_clk, active);
    end
    rst = 1'b1;
    step();
    n_tests++;
    if ({base_tick, cfg_ready, ch_tick, ch_clk, active} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_mid_clear got bt=%b rdy=%b tick=%b clk=%b act=%b required all 0",
               base_tick, cfg_ready, ch_tick, ch_clk, active);
    end
    rst = 1'b0;
    cyc = 0;
    $display("[TB] reset pulsed mid-operation");
    for (int k = 0; k < 4; k++) begin
      step();
      exp_bt = (cyc == 4);
      n_tests++;
      if ({base_tick, ch_tick, ch_clk, active} !== {exp_bt, 12'd0}) begin
        n_fail++;
        $display("FAIL reset_mid_phase cyc=%0d got bt=%b tick=%b clk=%b act=%b required bt=%b rest 0",
                 cyc, base_tick, ch_tick, ch_clk, active, exp_bt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_terminal();
    test_disable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
